// File: rtl/relu_stream.sv
// relu_stream: streaming ReLU / leaky-ReLU stage.
//
// A run of floating-point elements is accepted from the upstream stream,
// passed through a two-register pipeline (stage 1 holds the raw word, stage 2
// holds the flp_relu result) and presented downstream. Both streams use
// valid/ready handshakes with full backpressure. A start command latches the
// run configuration. A one-cycle done pulse follows the last downstream
// transfer.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   i_start              start-run strobe, sampled only in IDLE
//   i_leaky, i_exp       run mode and leaky scale exponent (latched on start)
//   i_count              number of elements in the run (latched on start)
//   o_busy, o_done       run in progress / one-cycle completion pulse
//   i_vld, i_data, o_rdy upstream stream
//   o_vld, o_data, i_rdy downstream stream
`timescale 1ns/1ps

module relu_stream #(
    parameter int EWIDTH = 8,
    parameter int SWIDTH = 23,
    parameter int CWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     i_start,
    input  logic                     i_leaky,
    input  logic [6:0]               i_exp,
    input  logic [CWIDTH-1:0]        i_count,
    output logic                     o_busy,
    output logic                     o_done,
    input  logic                     i_vld,
    input  logic [EWIDTH+SWIDTH:0]   i_data,
    output logic                     o_rdy,
    output logic                     o_vld,
    output logic [EWIDTH+SWIDTH:0]   o_data,
    input  logic                     i_rdy
);

    localparam int W    = 1 + EWIDTH + SWIDTH;
    localparam int EMAX = (1 << EWIDTH) - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ReLU on one element. NaN and non-negative values always pass. In leaky
    // mode a negative finite value has i_exp added to its exponent. Results
    // that underflow the exponent range, and negative denormal inputs, flush
    // to -0; results that overflow saturate to -inf.
    function automatic logic [W-1:0] flp_relu(input logic [W-1:0] x,
                                              input logic       leaky,
                                              input logic [6:0] sc);
        logic [EWIDTH-1:0] e;
        logic [SWIDTH-1:0] m;
        logic              is_nan;
        int                e_new;
        e      = x[W-2:SWIDTH];
        m      = x[SWIDTH-1:0];
        is_nan = (&e) && (|m);
        e_new  = int'(e) + int'(signed'(sc));
        if (!x[W-1] || is_nan) begin
            return x;
        end else if (!leaky) begin
            return '0;
        end else if (&e) begin
            return x;
        end else if ((e == '0) || (e_new <= 0)) begin
            return {1'b1, {(W-1){1'b0}}};
        end else if (e_new >= EMAX) begin
            return {1'b1, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
        end else begin
            return {1'b1, e_new[EWIDTH-1:0], m};
        end
    endfunction

    state_t            state_q, state_d;
    logic              leaky_q, leaky_d;
    logic [6:0]        exp_q, exp_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [CWIDTH-1:0] icnt_q, icnt_d;
    logic [CWIDTH-1:0] ocnt_q, ocnt_d;
    logic              done_q, done_d;
    logic              s1_vld_q, s1_vld_d;
    logic [W-1:0]      s1_data_q, s1_data_d;
    logic              s2_vld_q, s2_vld_d;
    logic [W-1:0]      s2_data_q, s2_data_d;

    logic s2_load;
    logic s1_open;
    logic in_xfer;
    logic out_xfer;

    // Stage 2 loads whenever it is empty or being drained; stage 1 moves
    // into it on the same condition, so stage 1 can take a new word when it
    // is empty or emptying. This keeps one element per cycle with no bubbles.
    assign s2_load  = !s2_vld_q || i_rdy;
    assign s1_open  = !s1_vld_q || s2_load;
    assign o_rdy    = (state_q == RUN) && (icnt_q != cnt_q) && s1_open;
    assign in_xfer  = i_vld && o_rdy;
    assign out_xfer = s2_vld_q && i_rdy;

    assign o_busy = (state_q == RUN);
    assign o_done = done_q;
    assign o_vld  = s2_vld_q;
    assign o_data = s2_data_q;

    always_comb begin
        state_d   = state_q;
        leaky_d   = leaky_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        icnt_d    = icnt_q;
        ocnt_d    = ocnt_q;
        done_d    = 1'b0;
        s1_vld_d  = s1_vld_q;
        s1_data_d = s1_data_q;
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;

        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            // A bubble leaves the old data in place to avoid needless toggling.
            if (s1_vld_q) begin
                s2_data_d = flp_relu(s1_data_q, leaky_q, exp_q);
            end
        end

        if (s1_open) begin
            s1_vld_d = in_xfer;
            if (in_xfer) begin
                s1_data_d = i_data;
            end
        end

        if (in_xfer) begin
            icnt_d = icnt_q + CWIDTH'(1);
        end
        if (out_xfer) begin
            ocnt_d = ocnt_q + CWIDTH'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        state_d = RUN;
                        leaky_d = i_leaky;
                        exp_d   = i_exp;
                        cnt_d   = i_count;
                        icnt_d  = '0;
                        ocnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // The pipeline is empty once the last element has left, so
                // nothing is in flight when returning to IDLE.
                if (out_xfer && ((ocnt_q + CWIDTH'(1)) == cnt_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            leaky_q   <= 1'b0;
            exp_q     <= '0;
            cnt_q     <= '0;
            icnt_q    <= '0;
            ocnt_q    <= '0;
            done_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
        end else begin
            state_q   <= state_d;
            leaky_q   <= leaky_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            icnt_q    <= icnt_d;
            ocnt_q    <= ocnt_d;
            done_q    <= done_d;
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
        end
    end

endmodule

// File: tb/tb_relu_stream.sv
// tb_relu_stream: self-checking bench for relu_stream with FP32 parameters.
// Stimulus pushes expected results into a scoreboard queue as upstream words
// are accepted; each scenario task then pops and compares against what the
// DUT delivered downstream.
`timescale 1ns/1ps

module tb_relu_stream;

    logic        clk;
    logic        nrst;
    logic        i_start;
    logic        i_leaky;
    logic [6:0]  i_exp;
    logic [15:0] i_count;
    logic        o_busy;
    logic        o_done;
    logic        i_vld;
    logic [31:0] i_data;
    logic        o_rdy;
    logic        o_vld;
    logic [31:0] o_data;
    logic        i_rdy;

    int checks = 0;
    int errors = 0;

    // Scoreboard and per-run observations filled by run_stream.
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          acc_cyc_q[$];
    int          out_cyc_q[$];
    int          stall_errs;
    int          done_cnt;
    int          done_cyc;
    logic        busy_at_done;
    int          rdy_over;
    bit          timed_out;

    relu_stream #(.EWIDTH(8), .SWIDTH(23), .CWIDTH(16)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .i_start (i_start),
        .i_leaky (i_leaky),
        .i_exp   (i_exp),
        .i_count (i_count),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .i_vld   (i_vld),
        .i_data  (i_data),
        .o_rdy   (o_rdy),
        .o_vld   (o_vld),
        .o_data  (o_data),
        .i_rdy   (i_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (time %0t, required earlier end)", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference ReLU for FP32 elements.
    function automatic logic [31:0] ref_relu(input logic [31:0] x, input bit leaky, input int sc);
        int e;
        bit nan;
        e   = int'(x[30:23]);
        nan = (e == 255) && (x[22:0] != 23'd0);
        if (nan || !x[31]) return x;
        if (!leaky) return 32'h0000_0000;
        if (e == 255) return x;
        if (e == 0) return 32'h8000_0000;
        e = e + sc;
        if (e <= 0) return 32'h8000_0000;
        if (e >= 255) return 32'hff80_0000;
        return {1'b1, e[7:0], x[22:0]};
    endfunction

    // Starts a run, then drives src_q with random valid/ready and records
    // everything seen until three cycles after the first done pulse.
    task automatic run_stream(input int count, input bit leaky, input int sc,
                              input int vld_pct, input int rdy_pct,
                              input bit poke_start, input int max_cyc);
        int          idx;
        int          cyc;
        int          post;
        logic        prev_stall;
        logic [31:0] prev_data;
        exp_q.delete(); obs_q.delete(); acc_cyc_q.delete(); out_cyc_q.delete();
        stall_errs = 0; done_cnt = 0; done_cyc = -1; busy_at_done = 1'b0;
        rdy_over = 0; timed_out = 1'b0;
        idx = 0; cyc = 0; post = 0; prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        i_start = 1'b1; i_leaky = leaky; i_exp = sc[6:0]; i_count = 16'(count);
        i_vld = 1'b0; i_rdy = 1'b0;
        while (post < 3 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            i_start = poke_start && (cyc == 2);
            if (poke_start && cyc == 2) begin
                i_count = 16'd7; i_leaky = ~leaky; i_exp = 7'd5;
            end
            i_vld  = (idx < src_q.size()) && ($urandom_range(99) < vld_pct);
            i_data = (idx < src_q.size()) ? src_q[idx] : 32'hdead_beef;
            i_rdy  = ($urandom_range(99) < rdy_pct);
            #1;
            if (prev_stall && (!o_vld || o_data !== prev_data)) stall_errs++;
            prev_stall = o_vld && !i_rdy;
            prev_data  = o_data;
            if (o_rdy && acc_cyc_q.size() >= count) rdy_over++;
            if (i_vld && o_rdy) begin
                exp_q.push_back(ref_relu(i_data, leaky, sc));
                acc_cyc_q.push_back(cyc);
                idx++;
            end
            if (o_vld && i_rdy) begin
                obs_q.push_back(o_data);
                out_cyc_q.push_back(cyc);
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = o_busy;
                end
            end
            if (done_cnt > 0) post++;
        end
        timed_out = (post < 3);
        i_start = 1'b0; i_vld = 1'b0; i_rdy = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; i_start = 1'b0; i_leaky = 1'b0; i_exp = '0; i_count = '0;
        i_vld = 1'b0; i_data = '0; i_rdy = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_vld, o_rdy} !== 4'b0000 || o_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_values: busy/done/vld/rdy=%b data=%h, required 0000 and 00000000",
                     {o_busy, o_done, o_vld, o_rdy}, o_data);
        end
        @(negedge clk); @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_relu();
        logic [31:0] want[8];
        logic [31:0] e;
        want = '{32'h00000000, 32'h00000000, 32'h7f800000, 32'h00000000,
                 32'h7fffffff, 32'hffffffff, 32'h00000000, 32'h41800000};
        src_q = '{32'h00000000, 32'h80000000, 32'h7f800000, 32'hff800000,
                  32'h7fffffff, 32'hffffffff, 32'hc1800000, 32'h41800000};
        run_stream(8, 1'b0, 0, 100, 100, 1'b0, 60);
        checks++;
        if (timed_out || obs_q.size() != 8) begin
            errors++;
            $display("[TB] FAIL relu_count: got %0d outputs (timeout=%0d), required 8", obs_q.size(), timed_out);
        end
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q[i] !== want[i] || obs_q[i] !== e) begin
                errors++;
                $display("[TB] FAIL relu_data[%0d]: got %h, required %h", i, obs_q[i], want[i]);
            end
            checks++;
            if (out_cyc_q[i] !== acc_cyc_q[i] + 2) begin
                errors++;
                $display("[TB] FAIL relu_latency[%0d]: out cycle %0d, required %0d", i, out_cyc_q[i], acc_cyc_q[i] + 2);
            end
        end
        checks++;
        if (done_cnt != 1 || obs_q.size() == 0 || done_cyc != out_cyc_q[out_cyc_q.size()-1] + 1 || busy_at_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL relu_done: pulses %0d at cycle %0d busy %b, required 1 pulse after last output with busy 0",
                     done_cnt, done_cyc, busy_at_done);
        end
        checks++;
        if (acc_cyc_q.size() != 8 || acc_cyc_q[7] != acc_cyc_q[0] + 7) begin
            errors++;
            $display("[TB] FAIL relu_throughput: %0d accepts not contiguous, required 8 in 8 cycles", acc_cyc_q.size());
        end
    endtask

    task automatic test_leaky();
        logic [31:0] want[8];
        want = '{32'h00000000, 32'h80000000, 32'h7f800000, 32'hff800000,
                 32'h7fffffff, 32'hffffffff, 32'hbf800000, 32'h41800000};
        src_q = '{32'h00000000, 32'h80000000, 32'h7f800000, 32'hff800000,
                  32'h7fffffff, 32'hffffffff, 32'hc1800000, 32'h41800000};
        run_stream(8, 1'b1, -4, 100, 100, 1'b0, 60);
        checks++;
        if (timed_out || obs_q.size() != 8 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL leaky_count: got %0d outputs, %0d done pulses, required 8 and 1", obs_q.size(), done_cnt);
        end
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("[TB] FAIL leaky_data[%0d]: got %h, required %h", i, obs_q[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        src_q.delete();
        for (int i = 0; i < 16; i++) begin
            src_q.push_back($urandom());
        end
        run_stream(16, 1'b1, 3, 60, 50, 1'b0, 600);
        checks++;
        if (timed_out || obs_q.size() != 16 || exp_q.size() != 16) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d outputs for %0d accepts, required 16 each", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q[i] !== e) begin
                errors++;
                $display("[TB] FAIL bp_data[%0d]: got %h, required %h", i, obs_q[i], e);
            end
        end
        checks++;
        if (stall_errs != 0) begin
            errors++;
            $display("[TB] FAIL bp_stall_stable: %0d stall cycles changed output, required 0", stall_errs);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL bp_done: %0d pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_framing();
        src_q = '{32'h3f800000, 32'h40000000, 32'hc1800000, 32'h40400000, 32'h40800000};
        run_stream(3, 1'b0, 0, 100, 100, 1'b1, 60);
        checks++;
        if (acc_cyc_q.size() != 3 || obs_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL frame_accepts: accepted %0d sent %0d, required 3 and 3", acc_cyc_q.size(), obs_q.size());
        end
        checks++;
        if (rdy_over != 0) begin
            errors++;
            $display("[TB] FAIL frame_rdy_after_count: o_rdy high %0d cycles past count, required 0", rdy_over);
        end
        checks++;
        if (done_cnt != 1 || timed_out) begin
            errors++;
            $display("[TB] FAIL frame_done: %0d pulses, required 1", done_cnt);
        end
        checks++;
        if (obs_q.size() != 3 || obs_q[2] !== 32'h00000000 || obs_q[0] !== 32'h3f800000) begin
            errors++;
            $display("[TB] FAIL frame_config_held: outputs %p, required relu of first 3 words", obs_q);
        end
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        i_start = 1'b1; i_count = 16'd0; i_leaky = 1'b0;
        #1;
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done_early: o_done=%b before start sampled, required 0", o_done);
        end
        @(negedge clk);
        i_start = 1'b0;
        #1;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done: done=%b busy=%b, required 1 and 0", o_done, o_busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_after: done=%b busy=%b, required 0 and 0", o_done, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int sent;
        int got;
        bit seen;
        logic [31:0] words[2];
        words = '{32'hc0000000, 32'h3fc00000};
        @(negedge clk);
        i_start = 1'b1; i_count = 16'd1; i_leaky = 1'b0; i_exp = '0;
        i_vld = 1'b0; i_rdy = 1'b1; i_data = 32'h40000000;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            i_vld   = (cyc == 1);
            #1;
            seen = (o_done === 1'b1);
        end
        checks++;
        if (!seen || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_first_done: seen=%0d busy=%b, required done with busy 0", seen, o_busy);
        end
        i_start = 1'b1; i_count = 16'd2; i_leaky = 1'b1; i_exp = 7'h7f;
        i_vld = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_restart: busy=%b, required 1", o_busy);
        end
        sent = 0; got = 0; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            i_vld  = (sent < 2);
            i_data = words[sent < 2 ? sent : 1];
            #1;
            if (i_vld && o_rdy) sent++;
            if (o_vld && i_rdy) begin
                checks++;
                if (o_data !== ref_relu(words[got < 2 ? got : 1], 1'b1, -1)) begin
                    errors++;
                    $display("[TB] FAIL b2b_data[%0d]: got %h, required %h", got, o_data,
                             ref_relu(words[got < 2 ? got : 1], 1'b1, -1));
                end
                got++;
            end
            seen = (o_done === 1'b1);
        end
        i_vld = 1'b0;
        checks++;
        if (!seen || got != 2) begin
            errors++;
            $display("[TB] FAIL b2b_second_run: outputs %0d done=%0d, required 2 and 1", got, seen);
        end
    endtask

    task automatic test_midrun_reset();
        int acc;
        int cyc;
        logic [31:0] e;
        @(negedge clk);
        i_start = 1'b1; i_leaky = 1'b0; i_exp = '0; i_count = 16'd6;
        acc = 0; cyc = 0;
        while (acc < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0; i_vld = 1'b1; i_rdy = 1'b0;
            i_data  = 32'h3f800000 + acc;
            #1;
            if (o_rdy) acc++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (acc != 2 || o_vld !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pre_reset: accepted %0d vld=%b busy=%b, required 2, 1, 1", acc, o_vld, o_busy);
        end
        nrst = 1'b0; i_vld = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_vld, o_rdy} !== 4'b0000 || o_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_values: busy/done/vld/rdy=%b data=%h, required 0000 and 00000000",
                     {o_busy, o_done, o_vld, o_rdy}, o_data);
        end
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        src_q = '{32'hbf800000, 32'h3f800000, 32'h7fc00000, 32'h80000000};
        run_stream(4, 1'b0, 0, 100, 100, 1'b0, 40);
        checks++;
        if (timed_out || obs_q.size() != 4 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL mid_fresh_run: %0d outputs %0d done pulses, required 4 and 1", obs_q.size(), done_cnt);
        end
        for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q[i] !== e) begin
                errors++;
                $display("[TB] FAIL mid_fresh_data[%0d]: got %h, required %h", i, obs_q[i], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_relu();
        test_leaky();
        test_backpressure();
        test_framing();
        test_zero_count();
        test_back_to_back();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_stream.md
# relu_stream

Streaming ReLU / leaky-ReLU stage for the vector engine datapath. It takes a run of floating-point elements from the upstream vector-read stream, applies the combinational `flp_relu` function to each one through a two-stage register pipeline with full backpressure, and hands the results to the downstream writeback stream. A per-run element counter frames each operation, from a start command to a done pulse.

## Interface
Parameters:
- `EWIDTH`, 8: exponent width. The data word width W = 1+EWIDTH+SWIDTH.
- `SWIDTH`, 23: significand width.
- `CWIDTH`, 16: element counter width.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `i_start`  in  1  start-run strobe. Sampled only in IDLE.
- `i_leaky`  in  1  run mode: 0 = ReLU, 1 = leaky ReLU. Latched on start.
- `i_exp`  in  7  leaky scale exponent, two's complement. Negative inputs are scaled by 2^i_exp. Latched on start.
- `i_count`  in  CWIDTH  number of elements in the run. Latched on start.
- `o_busy`  out  1  high in RUN.
- `o_done`  out  1  one-cycle pulse when the run completes.
- `i_vld`  in  1  upstream data valid.
- `i_data`  in  W  upstream element.
- `o_rdy`  out  1  upstream ready. A transfer happens when `i_vld && o_rdy`.
- `o_vld`  out  1  downstream data valid.
- `o_data`  out  W  result element.
- `i_rdy`  in  1  downstream ready. A transfer happens when `o_vld && i_rdy`.

## Operation
- **FSM states:** IDLE and RUN.
- **IDLE → RUN:** on `i_start` with `i_count != 0`.
  - Latch `i_leaky`, `i_exp` and `i_count`.
  - Clear the input-accepted counter `icnt` and the output-sent counter `ocnt`.
- **Zero-length start:** `i_start` with `i_count == 0` stays in IDLE and pulses `o_done` on the next cycle.
- **`i_start` in RUN:** ignored. The latched config must not change mid-run.
- **Upstream ready:** `o_rdy` = RUN && `icnt != cnt` && stage-1 slot can accept. The slot can accept when stage 1 is empty or stage 1 advances this cycle.
  - Upstream words beyond the count are never accepted.
- **Stage 1:** registers `i_data` and a valid bit.
- **Stage 2:** registers `flp_relu(s1_data, leaky, exp)` and a valid bit. It drives `o_data` and `o_vld`.
- **Advance rule:** stage 2 loads when it is empty or `i_rdy` is high. Stage 1 advances into stage 2 whenever stage 2 loads.
  - This sustains one element per cycle with no bubbles under continuous valid/ready.
- **Stall:** while `o_vld && !i_rdy`, `o_data` holds stable and no pipeline register changes, except an empty stage 1 may still fill.
- **Counters:** `icnt` increments on each upstream transfer; `ocnt` increments on each downstream transfer. Both have width CWIDTH and never wrap within a run.
- **RUN → IDLE:** on the downstream transfer that makes `ocnt == cnt`. `o_done` pulses in the following cycle and `o_busy` drops in that same cycle.
- **ReLU function** (FP32 examples):
  - ReLU mode: negative finite or -inf → +0; -0 → +0; NaN passes unchanged (for example ffffffff → ffffffff); positive values pass.
  - Leaky mode: negative values get exponent + `i_exp`; ±0, ±inf and NaN pass unchanged.
  - Leaky example with `i_exp` = -4: c1800000 → bf800000.
- **Reset:** asynchronous and takes effect mid-run. It returns the block to IDLE, clears both valid bits and both counters, and abandons any in-flight elements.

## Timing
- **Reset values:** `o_busy`=0, `o_done`=0, `o_vld`=0, `o_rdy`=0, `o_data`=0.
- **Latency:** an upstream transfer in cycle N appears as `o_vld` with its result in cycle N+2, assuming no stall.
- **Throughput:** 1 element per cycle.
- **Start-up:** `o_rdy` can first be high in the cycle after `i_start` is sampled.
- **Completion:** for a count of C with no stalls and the first accept at cycle S, the last `o_vld` is at S+C+1 and `o_done` is at S+C+2.
- **Ready-valid independence:** `o_rdy` has no combinational dependence on `i_vld`. `o_vld` has no combinational dependence on `i_rdy`. `o_rdy` may depend combinationally on `i_rdy` through the advance rule.
- **Back-to-back runs:** a new `i_start` is accepted in the cycle `o_done` is high. The block is already in IDLE then.

## Test plan
- **ReLU run:** count=8, leaky=0, stream 00000000, 80000000, 7f800000, ff800000, 7fffffff, ffffffff, c1800000, 41800000 → outputs 00000000, 00000000, 7f800000, 00000000, 7fffffff, ffffffff, 00000000, 41800000 in order, each 2 cycles after accept, then one `o_done` pulse.
- **Leaky run:** same stream with leaky=1 and exp=-4 → 00000000, 80000000, 7f800000, ff800000, 7fffffff, ffffffff, bf800000, 41800000.
- **Backpressure:** count=16 with random `i_vld` and `i_rdy` patterns → no element lost, duplicated or reordered, and `o_data` is stable throughout every stall.
- **Framing:** count=3 while upstream keeps `i_vld` high for 5 words → exactly 3 words accepted, `o_rdy` low afterwards, `o_done` once, `i_start` ignored during RUN. A count=0 start → `o_done` next cycle with `o_busy` never high.
- **Mid-run reset:** assert `nrst` low after 2 of 6 elements have been accepted → all outputs return to reset values immediately, and a fresh run of 4 elements then completes correctly.
